ray_march_engine: RTL and testbench

- Parametrised successor to the single-ray marcher. Marches one ray per transaction with valid/ready handshakes on ray input, scene-query channel and result channel.
- Scene SDF is external, sits behind a request/response interface, and may have any latency.
- Sits between the per-pixel ray generator (upstream) and the shading/pixel-writer stage (downstream).

---
 rtl/ray_march_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_ray_march_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_march_engine.sv
// ray_march_engine
//   Sphere-traces one ray per transaction against an external scene SDF.
//   Per step: pos = ro + rd*t, query the scene, then advance t by the returned
//   distance until the ray hits the surface, leaves MAX_DIST, or uses up
//   MAX_STEPS queries. Fixed-point is signed Q(WIDTH-FRAC).FRAC.
//
//   Optional build macro: RAYMARCH_TIMEOUT_EN
//     Adds a watchdog in WAIT and the res_timeout output. A stalled scene then
//     ends the ray as a miss after TIMEOUT_CYCLES cycles.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start_valid/start_ready    ray handshake; ready only while idle
//   ro_x/y/z, rd_x/y/z         ray origin and normalised direction
//   sdf_req_valid/ready        scene query handshake
//   sdf_pos_x/y/z              query position, held while the request waits
//   sdf_rsp_valid, sdf_rsp_dist scene answer; only used in WAIT
//   res_valid/ready            result handshake
//   res_dist, res_hit, res_steps final t, hit flag, queries issued
//   res_timeout                watchdog fired (RAYMARCH_TIMEOUT_EN only)
module ray_march_engine #(
   parameter int               WIDTH          = 32,
   parameter int               FRAC           = 24,
   parameter int               MAX_STEPS      = 100,
   parameter int               STEP_W         = 8,
   parameter logic [WIDTH-1:0] MAX_DIST       = 32'h64000000,
   parameter logic [WIDTH-1:0] SURFACE_DIST   = 32'h00028F5C,
   parameter int               TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [WIDTH-1:0]  ro_x,
   input  logic [WIDTH-1:0]  ro_y,
   input  logic [WIDTH-1:0]  ro_z,
   input  logic [WIDTH-1:0]  rd_x,
   input  logic [WIDTH-1:0]  rd_y,
   input  logic [WIDTH-1:0]  rd_z,
   output logic              sdf_req_valid,
   input  logic              sdf_req_ready,
   output logic [WIDTH-1:0]  sdf_pos_x,
   output logic [WIDTH-1:0]  sdf_pos_y,
   output logic [WIDTH-1:0]  sdf_pos_z,
   input  logic              sdf_rsp_valid,
   input  logic [WIDTH-1:0]  sdf_rsp_dist,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [WIDTH-1:0]  res_dist,
   output logic              res_hit,
   output logic [STEP_W-1:0] res_steps
`ifdef RAYMARCH_TIMEOUT_EN
   ,
   output logic              res_timeout
`endif
);

   typedef enum logic [2:0] {IDLE, POS, REQ, WAIT, EVAL, RESULT} state_t;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Signed add clamped to the representable range.
   function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] s;
      s = a + b;
      if ((a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]))
         s = a[WIDTH-1] ? SMIN : SMAX;
      return s;
   endfunction

   // One axis of ro + (rd*t >>> FRAC): full-width product, arithmetic shift,
   // truncate, then saturating add onto the origin.
   function automatic logic [WIDTH-1:0] axis_pos(input logic [WIDTH-1:0] o,
                                                 input logic [WIDTH-1:0] dir,
                                                 input logic [WIDTH-1:0] t);
      logic signed [2*WIDTH-1:0] prod;
      logic signed [2*WIDTH-1:0] sh;
      prod = $signed({{WIDTH{dir[WIDTH-1]}}, dir}) * $signed({{WIDTH{t[WIDTH-1]}}, t});
      sh   = prod >>> FRAC;
      return sat_add(o, sh[WIDTH-1:0]);
   endfunction

   state_t                  state_q, state_d;
   logic [2:0][WIDTH-1:0]   ro_q, ro_d;
   logic [2:0][WIDTH-1:0]   rd_q, rd_d;
   logic [2:0][WIDTH-1:0]   pos_q, pos_d;
   logic [WIDTH-1:0]        t_q, t_d;
   logic [WIDTH-1:0]        d_q, d_d;
   logic [STEP_W-1:0]       steps_q, steps_d;
   logic [WIDTH-1:0]        res_dist_q, res_dist_d;
   logic                    res_hit_q, res_hit_d;
   logic [STEP_W-1:0]       res_steps_q, res_steps_d;
   logic [WIDTH-1:0]        new_t;

`ifdef RAYMARCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]         wcnt_q, wcnt_d;
   logic                    res_timeout_q, res_timeout_d;
`endif

   always_comb begin
      state_d     = state_q;
      ro_d        = ro_q;
      rd_d        = rd_q;
      pos_d       = pos_q;
      t_d         = t_q;
      d_d         = d_q;
      steps_d     = steps_q;
      res_dist_d  = res_dist_q;
      res_hit_d   = res_hit_q;
      res_steps_d = res_steps_q;
`ifdef RAYMARCH_TIMEOUT_EN
      wcnt_d        = wcnt_q;
      res_timeout_d = res_timeout_q;
`endif
      new_t = sat_add(t_q, d_q);

      case (state_q)
         IDLE: begin
            if (start_valid && start_ready) begin
               ro_d    = {ro_z, ro_y, ro_x};
               rd_d    = {rd_z, rd_y, rd_x};
               t_d     = '0;
               steps_d = '0;
               state_d = POS;
            end
         end
         POS: begin
            for (int i = 0; i < 3; i++)
               pos_d[i] = axis_pos(ro_q[i], rd_q[i], t_q);
            state_d = REQ;
         end
         REQ: begin
            if (sdf_req_ready) begin
               steps_d = steps_q + 1'b1;
`ifdef RAYMARCH_TIMEOUT_EN
               wcnt_d  = '0;
`endif
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (sdf_rsp_valid) begin
               d_d     = sdf_rsp_dist;
               state_d = EVAL;
            end
`ifdef RAYMARCH_TIMEOUT_EN
            else if (wcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               res_dist_d    = t_q;
               res_hit_d     = 1'b0;
               res_steps_d   = steps_q;
               res_timeout_d = 1'b1;
               state_d       = RESULT;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
`endif
         end
         EVAL: begin
            res_steps_d = steps_q;
`ifdef RAYMARCH_TIMEOUT_EN
            res_timeout_d = 1'b0;
`endif
            // Negative distances (inside the surface) also count as a hit.
            if ($signed(d_q) < $signed(SURFACE_DIST)) begin
               res_dist_d = t_q;
               res_hit_d  = 1'b1;
               state_d    = RESULT;
            end else begin
               t_d = new_t;
               if (($signed(new_t) > $signed(MAX_DIST)) ||
                   (steps_q == STEP_W'(MAX_STEPS))) begin
                  res_dist_d = new_t;
                  res_hit_d  = 1'b0;
                  state_d    = RESULT;
               end else begin
                  state_d = POS;
               end
            end
         end
         RESULT: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ro_q        <= '0;
         rd_q        <= '0;
         pos_q       <= '0;
         t_q         <= '0;
         d_q         <= '0;
         steps_q     <= '0;
         res_dist_q  <= '0;
         res_hit_q   <= 1'b0;
         res_steps_q <= '0;
`ifdef RAYMARCH_TIMEOUT_EN
         wcnt_q        <= '0;
         res_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ro_q        <= ro_d;
         rd_q        <= rd_d;
         pos_q       <= pos_d;
         t_q         <= t_d;
         d_q         <= d_d;
         steps_q     <= steps_d;
         res_dist_q  <= res_dist_d;
         res_hit_q   <= res_hit_d;
         res_steps_q <= res_steps_d;
`ifdef RAYMARCH_TIMEOUT_EN
         wcnt_q        <= wcnt_d;
         res_timeout_q <= res_timeout_d;
`endif
      end
   end

   assign start_ready   = (state_q == IDLE) && !rst;
   assign sdf_req_valid = (state_q == REQ);
   assign sdf_pos_x     = pos_q[0];
   assign sdf_pos_y     = pos_q[1];
   assign sdf_pos_z     = pos_q[2];
   assign res_valid     = (state_q == RESULT);
   assign res_dist      = res_dist_q;
   assign res_hit       = res_hit_q;
   assign res_steps     = res_steps_q;
`ifdef RAYMARCH_TIMEOUT_EN
   assign res_timeout   = res_timeout_q;
`endif

endmodule

// File: tb/tb_ray_march_engine.sv
module tb_ray_march_engine;

   localparam longint SMAXL = 64'sd2147483647;
   localparam longint SMINL = -64'sd2147483648;
   localparam longint MAXD  = 64'sd1677721600;   // 100.0
   localparam longint SURF  = 64'sd167772;       // 0.01
   localparam int     NSTEP = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [31:0] ro_x = '0, ro_y = '0, ro_z = '0;
   logic [31:0] rd_x = '0, rd_y = '0, rd_z = '0;
   logic        sdf_req_valid;
   logic        sdf_req_ready = 1'b0;
   logic [31:0] sdf_pos_x, sdf_pos_y, sdf_pos_z;
   logic        sdf_rsp_valid = 1'b0;
   logic [31:0] sdf_rsp_dist = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_dist;
   logic        res_hit;
   logic [7:0]  res_steps;
`ifdef RAYMARCH_TIMEOUT_EN
   logic        res_timeout;
`endif

   int errors = 0;
   int checks = 0;

   // Scene answers, one per query, loaded by each test.
   logic [31:0] dq [0:NSTEP-1];
   // Result observed by the last run_ray call.
   logic [31:0] got_dist;
   logic        got_hit;
   logic [7:0]  got_steps;
   int          got_nreq;
   logic [31:0] got_pos2_z;

   ray_march_engine #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .ro_x(ro_x), .ro_y(ro_y), .ro_z(ro_z),
      .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z),
      .sdf_req_valid(sdf_req_valid), .sdf_req_ready(sdf_req_ready),
      .sdf_pos_x(sdf_pos_x), .sdf_pos_y(sdf_pos_y), .sdf_pos_z(sdf_pos_z),
      .sdf_rsp_valid(sdf_rsp_valid), .sdf_rsp_dist(sdf_rsp_dist),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_dist(res_dist), .res_hit(res_hit), .res_steps(res_steps)
`ifdef RAYMARCH_TIMEOUT_EN
      , .res_timeout(res_timeout)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference arithmetic (plain integers) ----------------
   function automatic logic [31:0] m_sat(input longint v);
      longint c;
      logic [63:0] b;
      c = (v > SMAXL) ? SMAXL : ((v < SMINL) ? SMINL : v);
      b = c;
      return b[31:0];
   endfunction

   function automatic logic [31:0] m_pos(input logic [31:0] o, input logic [31:0] dir,
                                         input longint t);
      longint p;
      logic [63:0] pv;
      logic [31:0] off;
      p   = longint'($signed(dir)) * t;
      p   = p >>> 24;
      pv  = p;
      off = pv[31:0];
      return m_sat(longint'($signed(o)) + longint'($signed(off)));
   endfunction

   task automatic tick;
      @(posedge clk); #1;
   endtask

   // Marches one ray, playing the scene from dq[] and checking every query
   // position, the step-to-step latency and the final result against the model.
   task automatic run_ray(input logic [31:0] ox, input logic [31:0] oy, input logic [31:0] oz,
                          input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dz,
                          input int req_stall, input int rsp_lat, input int res_stall,
                          input bit spurious);
      longint      tm;
      int          q, n, en;
      bit          done, ehit;
      logic [95:0] exp_pos, hold;
      logic [31:0] hd;
      logic        hh;
      logic [7:0]  hs;
      tm = 0; q = 0; done = 0; ehit = 0; got_nreq = 0; got_pos2_z = 'x;
      ro_x = ox; ro_y = oy; ro_z = oz; rd_x = dx; rd_y = dy; rd_z = dz;
      start_valid = 1'b1;
      n = 0;
      while (!start_ready && n < 50) begin tick(); n++; end
      checks++;
      if (start_ready !== 1'b1) begin
         errors++; $display("FAIL start_accept: start_ready=%b required 1", start_ready);
         start_valid = 1'b0;
         return;
      end
      tick();
      start_valid = 1'b0;
      forever begin
         n = 0;
         while (!(sdf_req_valid || res_valid) && n < 300) begin tick(); n++; end
         checks++;
         if (n >= 300) begin
            errors++; $display("FAIL step_wait: no request or result within bound (q=%0d)", q);
            break;
         end
         checks++;
         if (res_valid !== done) begin
            errors++;
            $display("FAIL termination: res_valid=%b required %b after %0d queries", res_valid, done, q);
            break;
         end
         en = (q == 0 || done) ? 1 : 2;
         checks++;
         if (n !== en) begin
            errors++; $display("FAIL latency: %0d cycles required %0d (q=%0d)", n, en, q);
         end
         if (done) break;
         exp_pos = {m_pos(oz, dz, tm), m_pos(oy, dy, tm), m_pos(ox, dx, tm)};
         checks++;
         if ({sdf_pos_z, sdf_pos_y, sdf_pos_x} !== exp_pos) begin
            errors++;
            $display("FAIL query_pos q=%0d: got %h required %h", q,
                     {sdf_pos_z, sdf_pos_y, sdf_pos_x}, exp_pos);
         end
         if (q == 1) got_pos2_z = sdf_pos_z;
         hold = {sdf_pos_z, sdf_pos_y, sdf_pos_x};
         for (int s = 0; s < req_stall; s++) begin
            if (spurious) begin
               sdf_rsp_valid = 1'($urandom_range(0, 1));
               sdf_rsp_dist  = $urandom;
            end
            tick();
            checks++;
            if (sdf_req_valid !== 1'b1 || {sdf_pos_z, sdf_pos_y, sdf_pos_x} !== hold) begin
               errors++;
               $display("FAIL req_hold: valid=%b pos=%h required 1 / %h", sdf_req_valid,
                        {sdf_pos_z, sdf_pos_y, sdf_pos_x}, hold);
            end
         end
         sdf_rsp_valid = 1'b0;
         sdf_req_ready = 1'b1;
         tick();
         sdf_req_ready = 1'b0;
         got_nreq++;
         for (int s = 0; s < rsp_lat; s++) tick();
         sdf_rsp_valid = 1'b1;
         sdf_rsp_dist  = dq[q];
         tick();
         sdf_rsp_valid = 1'b0;
         // model step
         if (longint'($signed(dq[q])) < SURF) begin
            ehit = 1; done = 1;
         end else begin
            tm = longint'($signed(m_sat(tm + longint'($signed(dq[q])))));
            if (tm > MAXD || q + 1 == NSTEP) done = 1;
         end
         q++;
      end
      if (!(done && res_valid === 1'b1)) return;
      got_dist = res_dist; got_hit = res_hit; got_steps = res_steps;
      checks++;
      if (res_dist !== m_sat(tm) || res_hit !== ehit || res_steps !== 8'(q)) begin
         errors++;
         $display("FAIL result: dist=%h hit=%b steps=%0d required %h %b %0d",
                  res_dist, res_hit, res_steps, m_sat(tm), ehit, q);
      end
      checks++;
      if (got_nreq !== q) begin
         errors++; $display("FAIL req_count: %0d handshakes required %0d", got_nreq, q);
      end
`ifdef RAYMARCH_TIMEOUT_EN
      checks++;
      if (res_timeout !== 1'b0) begin
         errors++; $display("FAIL res_timeout_clear: got %b required 0", res_timeout);
      end
`endif
      hd = res_dist; hh = res_hit; hs = res_steps;
      for (int s = 0; s < res_stall; s++) begin
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_dist !== hd || res_hit !== hh || res_steps !== hs ||
             start_ready !== 1'b0) begin
            errors++;
            $display("FAIL res_hold: valid=%b dist=%h hit=%b steps=%0d start_ready=%b",
                     res_valid, res_dist, res_hit, res_steps, start_ready);
         end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
         errors++;
         $display("FAIL res_release: res_valid=%b start_ready=%b required 0 1", res_valid, start_ready);
      end
   endtask

   // ---------------------------- tests ----------------------------
   task automatic test_reset;
      rst = 1'b1;
      tick();
      checks++;
      if (start_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready_in_rst: got %b required 0", start_ready);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({start_ready, sdf_req_valid, res_valid, res_hit} !== 4'b1000 ||
          res_dist !== 32'h0 || res_steps !== 8'h0 ||
          {sdf_pos_x, sdf_pos_y, sdf_pos_z} !== 96'h0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b req=%b res=%b hit=%b dist=%h steps=%0d pos=%h",
                  start_ready, sdf_req_valid, res_valid, res_hit, res_dist, res_steps,
                  {sdf_pos_x, sdf_pos_y, sdf_pos_z});
      end
   endtask

   task automatic test_hit;
      dq[0] = 32'h04000000; dq[1] = 32'h00014000;
      run_ray(0, 0, 0, 0, 0, 32'h01000000, 0, 0, 0, 0);
      checks++;
      if (got_dist !== 32'h04000000 || got_hit !== 1'b1 || got_steps !== 8'd2 ||
          got_pos2_z !== 32'h04000000) begin
         errors++;
         $display("FAIL hit: dist=%h hit=%b steps=%0d pos2z=%h required 04000000 1 2 04000000",
                  got_dist, got_hit, got_steps, got_pos2_z);
      end
   endtask

   task automatic test_max_dist;
      for (int i = 0; i < NSTEP; i++) dq[i] = 32'h3C000000;
      run_ray(0, 0, 0, 0, 0, 32'h01000000, 0, 1, 0, 0);
      checks++;
      if (got_dist !== 32'h78000000 || got_hit !== 1'b0 || got_steps !== 8'd2) begin
         errors++;
         $display("FAIL max_dist: dist=%h hit=%b steps=%0d required 78000000 0 2",
                  got_dist, got_hit, got_steps);
      end
   endtask

   task automatic test_step_limit;
      for (int i = 0; i < NSTEP; i++) dq[i] = 32'h01000000;
      run_ray(0, 0, 0, 32'h01000000, 0, 0, 0, 0, 0, 0);
      checks++;
      if (got_dist !== 32'h64000000 || got_hit !== 1'b0 || got_steps !== 8'd100 ||
          got_nreq !== 100) begin
         errors++;
         $display("FAIL step_limit: dist=%h hit=%b steps=%0d reqs=%0d required 64000000 0 100 100",
                  got_dist, got_hit, got_steps, got_nreq);
      end
   endtask

   task automatic test_backpressure;
      dq[0] = 32'h02000000; dq[1] = 32'h00800000; dq[2] = 32'hFFFF0000;
      for (int i = 3; i < NSTEP; i++) dq[i] = 32'h01000000;
      run_ray(32'h00400000, 32'hFF000000, 0, 32'h00B504F3, 32'h00B504F3, 0, 5, 2, 7, 0);
   endtask

   task automatic test_reset_mid_wait;
      int n;
      ro_x = 0; ro_y = 0; ro_z = 0; rd_x = 0; rd_y = 0; rd_z = 32'h01000000;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      n = 0;
      while (!sdf_req_valid && n < 20) begin tick(); n++; end
      sdf_req_ready = 1'b1;
      tick();
      sdf_req_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (start_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid_wait_ready: got %b required 1", start_ready);
      end
      sdf_rsp_valid = 1'b1; sdf_rsp_dist = 32'h00001000;
      tick();
      sdf_rsp_valid = 1'b0;
      tick();
      checks++;
      if (res_valid !== 1'b0 || sdf_req_valid !== 1'b0 || start_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_wait_ignore: res_valid=%b req_valid=%b start_ready=%b required 0 0 1",
                  res_valid, sdf_req_valid, start_ready);
      end
      test_hit();
   endtask

   task automatic test_random;
      logic [31:0] o [3];
      logic [31:0] d [3];
      int r;
      for (int k = 0; k < 8; k++) begin
         for (int a = 0; a < 3; a++) begin
            o[a] = (k % 3 == 2) ? $urandom : 32'($urandom_range(0, 32'h08000000)) - 32'h04000000;
            d[a] = 32'($urandom_range(0, 32'h02000000)) - 32'h01000000;
         end
         for (int i = 0; i < NSTEP; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6)       dq[i] = 32'($urandom_range(0, 32'h28F5B));
            else if (r < 10) dq[i] = -32'($urandom_range(1, 32'h00100000));
            else             dq[i] = 32'($urandom_range(32'h00100000, 32'h14000000));
         end
         run_ray(o[0], o[1], o[2], d[0], d[1], d[2], $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1);
      end
   endtask

`ifdef RAYMARCH_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      ro_x = 0; ro_y = 0; ro_z = 0; rd_x = 32'h01000000; rd_y = 0; rd_z = 0;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      n = 0;
      while (!sdf_req_valid && n < 20) begin tick(); n++; end
      sdf_req_ready = 1'b1;
      tick();
      sdf_req_ready = 1'b0;
      n = 0;
      while (!res_valid && n < 100) begin tick(); n++; end
      checks++;
      if (n !== 16 || res_timeout !== 1'b1 || res_hit !== 1'b0 || res_steps !== 8'd1 ||
          res_dist !== 32'h0) begin
         errors++;
         $display("FAIL timeout: cycles=%0d to=%b hit=%b steps=%0d dist=%h required 16 1 0 1 0",
                  n, res_timeout, res_hit, res_steps, res_dist);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_hit();
      test_max_dist();
      test_step_limit();
      test_backpressure();
      test_reset_mid_wait();
      test_random();
`ifdef RAYMARCH_TIMEOUT_EN
      test_timeout();
      test_hit();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global time limit");
   end

endmodule
